// File: rtl/button_event_decoder.sv
// Turns a debounced button level into 1-cycle press/release/click/long/repeat pulses plus a held level.
// Latency: 1 cycle from sampling edge to pulse. No backpressure. Define AUTOREPEAT_EN to build the auto-repeat pulse.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iLevel,
    output logic oPress,
    output logic oRelease,
    output logic oClick,
    output logic oLong,
    output logic oRepeat,
    output logic oHeld
);

    localparam logic [1:0] ST_ARM     = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_PRESSED = 2'd2;
    localparam logic [1:0] ST_LONG    = 2'd3;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    generate
        if ((LONG_CYCLES < 2) || (REPEAT_CYCLES < 2) ||
            ((2 ** CNT_W) < LONG_CYCLES) || ((2 ** CNT_W) < REPEAT_CYCLES)) begin : g_bad_params
            $error("button_event_decoder: cycle counts out of range for CNT_W");
        end
    endgenerate

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             click_nxt;
    logic             long_nxt;
    logic             repeat_nxt;
    logic             held_nxt;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        click_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            ST_ARM: begin
                // A level already high out of reset must be released before it can count as a press.
                if (!iLevel) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (iLevel) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end
            end
            ST_PRESSED: begin
                // Release is tested first so it wins over a simultaneous terminal count.
                if (!iLevel) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                    click_nxt   = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = ST_LONG;
                    cnt_nxt   = '0;
                    long_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_LONG: begin
                if (!iLevel) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
`ifdef AUTOREPEAT_EN
                    if (cnt == REP_LAST) begin
                        cnt_nxt    = '0;
                        repeat_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
`else
                    cnt_nxt = '0;
`endif
                end
            end
            default: begin
                state_nxt = ST_ARM;
                cnt_nxt   = '0;
            end
        endcase
        held_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_LONG);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state    <= ST_ARM;
            cnt      <= '0;
            oPress   <= 1'b0;
            oRelease <= 1'b0;
            oClick   <= 1'b0;
            oLong    <= 1'b0;
            oRepeat  <= 1'b0;
            oHeld    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            oPress   <= press_nxt;
            oRelease <= release_nxt;
            oClick   <= click_nxt;
            oLong    <= long_nxt;
            oRepeat  <= repeat_nxt;
            oHeld    <= held_nxt;
        end
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the clean, debounced button level from the debouncer and turns it into single-cycle event pulses: press, release, short click, long press and, optionally, auto-repeat.
- Sits between the debouncer output and the control/display logic, so downstream logic never does its own edge or duration detection.
- One clock domain. All outputs are registered.

Parameters:
LONG_CYCLES, 8, number of consecutive high samples after the press event before oLong fires (legal range 2..2^CNT_W).
REPEAT_CYCLES, 4, high samples between consecutive oRepeat pulses once in the long-press state (legal range 2..2^CNT_W).
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W >= max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
iClk  input  1  system clock, rising-edge active
iReset  input  1  synchronous, active-high reset
iLevel  input  1  debounced button level (1 = pressed), already synchronous to iClk
oPress  output  1  1-cycle pulse on press
oRelease  output  1  1-cycle pulse on any release
oClick  output  1  1-cycle pulse on release before oLong fired (short press)
oLong  output  1  1-cycle pulse when the hold reaches LONG_CYCLES
oRepeat  output  1  1-cycle pulse every REPEAT_CYCLES while held past long press
oHeld  output  1  level, 1 while the FSM is in PRESSED or LONG

Behaviour:
- Reset (iReset=1 at a rising edge):
  - all outputs 0, counter 0, state ARM.
  - Reset has priority over every other event, including mid-press.
- States: ARM, IDLE, PRESSED, LONG. Transitions are evaluated on the value of iLevel sampled at each rising edge.
- ARM: waits for iLevel=0, then goes to IDLE. No events are generated. A button held through reset therefore produces no oPress until it is released and pressed again.
- IDLE, iLevel=1:
  - oPress=1 in the following cycle.
  - state PRESSED, cnt<=0, oHeld=1.
- PRESSED, iLevel=1: cnt<=cnt+1. When cnt==LONG_CYCLES-1:
  - oLong=1 in the following cycle.
  - state LONG, cnt<=0.
  - oLong therefore appears LONG_CYCLES cycles after oPress.
- PRESSED, iLevel=0:
  - oRelease=1 and oClick=1 in the following cycle.
  - state IDLE, cnt<=0, oHeld=0.
- LONG, iLevel=1: cnt<=cnt+1. When cnt==REPEAT_CYCLES-1, oRepeat=1 and cnt<=0 (only when the auto-repeat feature is compiled in).
- LONG, iLevel=0:
  - oRelease=1, oClick=0.
  - state IDLE, cnt<=0, oHeld=0.
- Latency: every event pulse appears exactly 1 cycle after the sampling edge that caused it. Each pulse is exactly 1 cycle wide.
- Simultaneous events: release on the same edge at which the counter would reach its terminal value means release wins. No oLong or oRepeat is produced.
- The counter never exceeds max(LONG_CYCLES, REPEAT_CYCLES)-1 and never wraps.
- Mutual exclusion:
  - At most one of oPress/oLong/oRepeat/oRelease is high in any cycle.
  - oClick is only ever high together with oRelease.
- A 1-cycle high pulse on iLevel in IDLE produces oPress followed by oRelease+oClick on the next cycle (back-to-back pulses are legal).

Optional Feature:
AUTOREPEAT_EN
- Defined: the LONG state counts and emits oRepeat every REPEAT_CYCLES cycles, with the first oRepeat arriving REPEAT_CYCLES cycles after oLong.
- Undefined:
  - oRepeat is tied to 0.
  - the LONG state holds cnt at 0.
  - REPEAT_CYCLES is ignored.
  - all other behaviour is identical.

Test Plan:
- Reset with iLevel=1 held, release reset, keep iLevel=1 for 20 cycles -> no outputs, oHeld=0. Then iLevel=0 for 1 cycle, then iLevel=1 -> oPress 1 cycle after that edge.
- From IDLE, iLevel=1 for 3 cycles, then 0 -> oPress at cycle 1, oRelease+oClick at cycle 4, oLong never fires, oHeld high for cycles 1-3.
- iLevel=1 for 20 cycles (LONG_CYCLES=8, REPEAT_CYCLES=4, AUTOREPEAT_EN defined) -> oPress at t=1, oLong at t=9, oRepeat at t=13 and t=17. Release -> oRelease with oClick=0.
- Same stimulus with AUTOREPEAT_EN undefined -> oLong at t=9, oRepeat stays 0, oRelease on release.
- Release on the exact edge where cnt==LONG_CYCLES-1 would be sampled -> oRelease+oClick, no oLong.
- Assert iReset while in LONG with iLevel=1 -> all outputs 0 the next cycle, state ARM, no oRelease generated.
